// File: rtl/hv_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : hv_timing_gen
// Brief    : Parametrised raster timing generator with frame-latched signed
//            sync offsets, look-ahead fetch position and blanked RGB output.
// Revision : 1.0 - initial release
// ============================================================================
module hv_timing_gen #(
    parameter int H_ACTIVE     = 336,
    parameter int H_TOTAL      = 456,
    parameter int H_SYNC_START = 360,
    parameter int H_SYNC_WIDTH = 24,
    parameter int V_ACTIVE     = 240,
    parameter int V_TOTAL      = 262,
    parameter int V_SYNC_START = 240,
    parameter int V_SYNC_WIDTH = 3,
    parameter int H_LEAD       = 1,
    parameter int CW           = 9,
    parameter int RGB_W        = 8
) (
    input  logic             MCLK,
    input  logic             RESET_N,
    input  logic             CE_PIX,
    input  logic [4:0]       HOFFS,
    input  logic [2:0]       VOFFS,
    input  logic [RGB_W-1:0] iRGB,
    output logic [CW-1:0]    HPOS,
    output logic [CW-1:0]    VPOS,
    output logic             HBLK,
    output logic             VBLK,
    output logic             HSYN,
    output logic             VSYN,
    output logic [RGB_W-1:0] oRGB,
    output logic             DE,
    output logic             VBL_START,
    output logic [7:0]       FRAME
);

    localparam logic [CW-1:0] c_H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] c_V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] c_H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW:0]   c_H_TOT_EXT = (CW+1)'(H_TOTAL);
    localparam logic [CW:0]   c_H_LEAD    = (CW+1)'(H_LEAD);

    localparam logic signed [CW+1:0] c_HS_NOM = (CW+2)'(H_SYNC_START);
    localparam logic signed [CW+1:0] c_HS_MIN = (CW+2)'(H_ACTIVE);
    localparam logic signed [CW+1:0] c_HS_MAX = (CW+2)'(H_TOTAL - H_SYNC_WIDTH);
    localparam logic signed [CW+1:0] c_HS_W   = (CW+2)'(H_SYNC_WIDTH);
    localparam logic signed [CW+1:0] c_VS_NOM = (CW+2)'(V_SYNC_START);
    localparam logic signed [CW+1:0] c_VS_MIN = (CW+2)'(V_ACTIVE);
    localparam logic signed [CW+1:0] c_VS_MAX = (CW+2)'(V_TOTAL - V_SYNC_WIDTH);
    localparam logic signed [CW+1:0] c_VS_W   = (CW+2)'(V_SYNC_WIDTH);

    logic [CW-1:0]    r_hcnt;
    logic [CW-1:0]    r_vcnt;
    logic [7:0]       r_frame;
    logic [4:0]       r_hoffs;
    logic [2:0]       r_voffs;
    logic             r_hblk;
    logic             r_vblk;
    logic             r_hsyn;
    logic             r_vsyn;
    logic [RGB_W-1:0] r_rgb;
    logic             r_de;
    logic             r_vbl_start;

    logic             w_hwrap;
    logic             w_vwrap;
    logic             w_fwrap;
    logic [CW-1:0]    w_hcnt_nxt;
    logic [CW-1:0]    w_vcnt_nxt;
    logic [4:0]       w_hoffs_eff;
    logic [2:0]       w_voffs_eff;
    logic signed [CW+1:0] w_hoffs_ext;
    logic signed [CW+1:0] w_voffs_ext;
    logic signed [CW+1:0] w_hs_raw;
    logic signed [CW+1:0] w_vs_raw;
    logic signed [CW+1:0] w_hs_b;
    logic signed [CW+1:0] w_vs_b;
    logic signed [CW+1:0] w_hcnt_ext;
    logic signed [CW+1:0] w_vcnt_ext;
    logic             w_hsync_on;
    logic             w_vsync_on;
    logic [CW:0]      w_hpos_sum;

    // ------------------------------------------------------------------
    // Next-state counters
    // ------------------------------------------------------------------
    assign w_hwrap    = (r_hcnt == c_H_LAST);
    assign w_vwrap    = (r_vcnt == c_V_LAST);
    assign w_fwrap    = w_hwrap && w_vwrap;
    assign w_hcnt_nxt = w_hwrap ? '0 : r_hcnt + CW'(1);
    assign w_vcnt_nxt = !w_hwrap ? r_vcnt : (w_vwrap ? '0 : r_vcnt + CW'(1));

    // The offsets sampled on the wrap CE already govern the (0,0) position
    assign w_hoffs_eff = w_fwrap ? HOFFS : r_hoffs;
    assign w_voffs_eff = w_fwrap ? VOFFS : r_voffs;

    assign w_hoffs_ext = {{(CW-4){w_hoffs_eff[4]}}, w_hoffs_eff, 1'b0};
    assign w_voffs_ext = {{(CW-1){w_voffs_eff[2]}}, w_voffs_eff};
    assign w_hs_raw    = c_HS_NOM + w_hoffs_ext;
    assign w_vs_raw    = c_VS_NOM + w_voffs_ext;

    always_comb begin
        w_hs_b = w_hs_raw;
        if (w_hs_raw < c_HS_MIN) begin
            w_hs_b = c_HS_MIN;
        end else if (w_hs_raw > c_HS_MAX) begin
            w_hs_b = c_HS_MAX;
        end
        w_vs_b = w_vs_raw;
        if (w_vs_raw < c_VS_MIN) begin
            w_vs_b = c_VS_MIN;
        end else if (w_vs_raw > c_VS_MAX) begin
            w_vs_b = c_VS_MAX;
        end
    end

    assign w_hcnt_ext = {2'b00, w_hcnt_nxt};
    assign w_vcnt_ext = {2'b00, w_vcnt_nxt};
    assign w_hsync_on = (w_hcnt_ext >= w_hs_b) && (w_hcnt_ext < (w_hs_b + c_HS_W));
    assign w_vsync_on = (w_vcnt_ext >= w_vs_b) && (w_vcnt_ext < (w_vs_b + c_VS_W));

    // ------------------------------------------------------------------
    // Counters, frame number and latched offsets
    // ------------------------------------------------------------------
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hcnt  <= '0;
            r_vcnt  <= '0;
            r_frame <= '0;
            r_hoffs <= '0;
            r_voffs <= '0;
        end else if (CE_PIX) begin
            r_hcnt <= w_hcnt_nxt;
            r_vcnt <= w_vcnt_nxt;
            if (w_fwrap) begin
                r_frame <= r_frame + 8'd1;
                r_hoffs <= HOFFS;
                r_voffs <= VOFFS;
            end
        end
    end

    // ------------------------------------------------------------------
    // Flags and syncs, registered from next-state counters
    // ------------------------------------------------------------------
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hblk <= 1'b1;
            r_vblk <= 1'b1;
            r_hsyn <= 1'b1;
            r_vsyn <= 1'b1;
        end else if (CE_PIX) begin
            r_hblk <= (w_hcnt_nxt >= c_H_ACT);
            r_vblk <= (w_vcnt_nxt >= c_V_ACT);
            r_hsyn <= ~w_hsync_on;
            r_vsyn <= ~w_vsync_on;
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline and vertical-blank strobe
    // ------------------------------------------------------------------
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rgb       <= '0;
            r_de        <= 1'b0;
            r_vbl_start <= 1'b0;
        end else begin
            // Strobe is one MCLK wide even when CE_PIX is sparse
            r_vbl_start <= 1'b0;
            if (CE_PIX) begin
                r_rgb       <= (r_hblk | r_vblk) ? '0 : iRGB;
                r_de        <= ~(r_hblk | r_vblk);
                r_vbl_start <= (w_hcnt_nxt == '0) && (w_vcnt_nxt == c_V_ACT);
            end
        end
    end

    assign w_hpos_sum = {1'b0, r_hcnt} + c_H_LEAD;

    always_comb begin
        HPOS = CW'(w_hpos_sum);
        if (w_hpos_sum >= c_H_TOT_EXT) begin
            HPOS = CW'(w_hpos_sum - c_H_TOT_EXT);
        end
    end

    assign VPOS      = r_vcnt;
    assign HBLK      = r_hblk;
    assign VBLK      = r_vblk;
    assign HSYN      = r_hsyn;
    assign VSYN      = r_vsyn;
    assign oRGB      = r_rgb;
    assign DE        = r_de;
    assign VBL_START = r_vbl_start;
    assign FRAME     = r_frame;

endmodule
`default_nettype wire
